// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer steering one valid/ready input to one of four channels selected by {S1,S0}.
// Latency: a word accepted in cycle t is on Dn with Dn_valid=1 in cycle t+1; one word per cycle per draining channel.
// Backpressure: in_ready drops only when the selected channel is full and its consumer is not ready; other channels drain freely.
module demux1to4_stream #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          S0,
  input  logic          S1,
  output logic          D0_valid,
  output logic          D1_valid,
  output logic          D2_valid,
  output logic          D3_valid,
  input  logic          D0_ready,
  input  logic          D1_ready,
  input  logic          D2_ready,
  input  logic          D3_ready,
  output logic [W-1:0]  D0,
  output logic [W-1:0]  D1,
  output logic [W-1:0]  D2,
  output logic [W-1:0]  D3,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);

  logic [1:0]    ch;
  logic [3:0]    d_ready;
  logic [3:0]    d_valid;
  logic [W-1:0]  d_data [4];
  logic [CW-1:0] cnt    [4];
  logic          in_fire;
  logic [3:0]    load;
  logic [3:0]    drain;

  assign ch      = {S1, S0};
  assign d_ready = {D3_ready, D2_ready, D1_ready, D0_ready};

  // Accept when the selected holding register is empty or emptying this cycle; never while in reset
  always_comb begin
    in_ready = rst_n & (~d_valid[ch] | d_ready[ch]);
    in_fire  = in_valid & in_ready;
  end

  // Per-channel load (input steered here) and drain (consumer takes the held word) strobes
  always_comb begin
    load  = 4'b0000;
    drain = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      load[n]  = in_fire && (ch == 2'(n));
      drain[n] = d_valid[n] && d_ready[n];
    end
  end

  // Holding registers, valid flags and transfer counters; a load wins over a drain so refill is bubble-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_valid <= 4'b0000;
      for (int n = 0; n < 4; n++) begin
        d_data[n] <= '0;
        cnt[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n]) begin
          d_data[n]  <= in_data;
          d_valid[n] <= 1'b1;
          cnt[n]     <= cnt[n] + CW'(1);
        end else if (drain[n]) begin
          d_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign D0_valid = d_valid[0];
  assign D1_valid = d_valid[1];
  assign D2_valid = d_valid[2];
  assign D3_valid = d_valid[3];
  assign D0       = d_data[0];
  assign D1       = d_data[1];
  assign D2       = d_data[2];
  assign D3       = d_data[3];
  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];
  assign cnt2     = cnt[2];
  assign cnt3     = cnt[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Bench for demux1to4_stream: directed scenarios followed by randomized traffic against a queue-based reference.
// Latency: expected words are queued at input acceptance and checked one cycle later by the monitor.
// Backpressure: the producer holds data/select while stalled; consumers' ready lines are randomized.
module tb_demux1to4_stream;
  localparam int W  = 2;
  localparam int CW = 2;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, S0, S1;
  logic [W-1:0]  in_data;
  logic          D0_valid, D1_valid, D2_valid, D3_valid;
  logic          D0_ready, D1_ready, D2_ready, D3_ready;
  logic [W-1:0]  D0, D1, D2, D3;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  demux1to4_stream #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .S0(S0), .S1(S1),
    .D0_valid(D0_valid), .D1_valid(D1_valid), .D2_valid(D2_valid), .D3_valid(D3_valid),
    .D0_ready(D0_ready), .D1_ready(D1_ready), .D2_ready(D2_ready), .D3_ready(D3_ready),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  logic [3:0]    dv, dr;
  logic [W-1:0]  dd [4];
  logic [CW-1:0] dc [4];
  assign dv = {D3_valid, D2_valid, D1_valid, D0_valid};
  assign dr = {D3_ready, D2_ready, D1_ready, D0_ready};
  assign dd[0] = D0;  assign dd[1] = D1;  assign dd[2] = D2;  assign dd[3] = D3;
  assign dc[0] = cnt0; assign dc[1] = cnt1; assign dc[2] = cnt2; assign dc[3] = cnt3;

  // Reference: each channel is a queue of words not yet taken by its consumer (at most one deep),
  // plus the last word a channel showed and the number of words it has received modulo 2^CW.
  int q [4][$];
  int last_word [4];
  int exp_cnt [4];
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every channel against the reference, then retires words the consumer takes
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int n = 0; n < 4; n++) begin
          int ev;
          int ed;
          ev = (q[n].size() > 0) ? 1 : 0;
          ed = (ev == 1) ? q[n][0] : last_word[n];
          chk($sformatf("valid%0d", n), int'(dv[n]), ev);
          chk($sformatf("data%0d", n), int'(dd[n]), ed);
          chk($sformatf("cnt%0d", n), int'(dc[n]), exp_cnt[n]);
          if (rst_n && ev == 1 && dr[n]) begin
            last_word[n] = q[n].pop_front();
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; the expected response is queued when the reference accepts the word
  task automatic cyc(input bit r, input bit v, input int d, input int s, input logic [3:0] rd,
                     output bit acc);
    bit exp_rdy;
    rst_n    = r;
    in_valid = v;
    in_data  = W'(d);
    {S1, S0} = 2'(s);
    {D3_ready, D2_ready, D1_ready, D0_ready} = rd;
    @(negedge clk);
    #1;
    // The monitor has already retired a drained word, so an empty queue here means "room this edge"
    exp_rdy = r && ((q[s].size() == 0) || rd[s]);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    acc = 1'b0;
    if (!r) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        last_word[n] = 0;
        exp_cnt[n]   = 0;
      end
    end else if (v && exp_rdy) begin
      q[s].push_back(d);
      exp_cnt[s] = (exp_cnt[s] + 1) % MOD;
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    bit pend;
    bit rv;
    int rdat, rsel;
    logic [3:0] rrd;
    bit rr;

    // Reset held for two cycles with a pending word for channel 2
    cyc(0, 1, 3, 2, 4'hF, acc);
    mon_en = 1'b1;
    cyc(0, 1, 3, 2, 4'hF, acc);
    // Release: the same word lands on D2 one cycle later
    cyc(1, 1, 3, 2, 4'hF, acc);
    chk("reset_release_accept", int'(acc), 1);
    cyc(1, 0, 0, 0, 4'hF, acc);
    chk("d2_after_release", int'(D2), 3);

    // Select sweep with all consumers ready
    cyc(1, 1, 0, 0, 4'hF, acc);
    cyc(1, 1, 1, 1, 4'hF, acc);
    cyc(1, 1, 3, 2, 4'hF, acc);
    cyc(1, 1, 3, 3, 4'hF, acc);
    cyc(1, 0, 0, 0, 4'hF, acc);
    cyc(1, 0, 0, 0, 4'hF, acc);

    // Backpressure on channel 1
    cyc(1, 1, 2, 1, 4'b1101, acc);
    cyc(1, 1, 1, 1, 4'b1101, acc);
    chk("bp_second_stalled", int'(acc), 0);
    cyc(1, 1, 1, 1, 4'b1101, acc);
    chk("bp_d1_stable", int'(D1), 2);
    cyc(1, 1, 1, 1, 4'b1111, acc);
    chk("bp_second_accepted", int'(acc), 1);
    cyc(1, 0, 0, 0, 4'hF, acc);
    chk("bp_d1_second", int'(D1), 1);

    // Full channel 1 does not block a word for channel 3
    cyc(1, 1, 3, 1, 4'b1101, acc);
    cyc(1, 1, 2, 3, 4'b1101, acc);
    chk("other_ch_accept", int'(acc), 1);
    cyc(1, 0, 0, 0, 4'b1101, acc);
    chk("other_ch_d3", int'(D3), 2);
    chk("other_ch_d1_held", int'(D1), 3);
    cyc(1, 0, 0, 0, 4'hF, acc);

    // Drain and refill channel 0 in the same cycle
    cyc(1, 1, 1, 0, 4'hF, acc);
    cyc(1, 1, 2, 0, 4'hF, acc);
    chk("refill_accept", int'(acc), 1);
    cyc(1, 0, 0, 0, 4'hF, acc);

    // Counter wrap on channel 2, then reset in the middle of a stalled stream
    for (int k = 0; k < 5; k++) cyc(1, 1, k % 4, 2, 4'hF, acc);
    cyc(1, 1, 1, 2, 4'b0000, acc);
    cyc(1, 1, 2, 0, 4'b0000, acc);
    cyc(0, 1, 3, 2, 4'b0000, acc);
    cyc(1, 0, 0, 0, 4'b0000, acc);
    chk("midreset_cnt2", int'(cnt2), 0);

    // Randomized traffic; a stalled word is held until accepted
    pend = 1'b0;
    rv = 1'b0; rdat = 0; rsel = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        rv   = ($urandom_range(3) != 0);
        rdat = $urandom_range(3);
        rsel = $urandom_range(3);
      end
      for (int n = 0; n < 4; n++) rrd[n] = ($urandom_range(9) < 6);
      rr = ($urandom_range(79) != 0);
      cyc(rr, rv, rdat, rsel, rrd, acc);
      pend = rr && rv && !acc;
    end
    cyc(1, 0, 0, 0, 4'hF, acc);
    cyc(1, 0, 0, 0, 4'hF, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer. It is the distribution-side counterpart of the 4:1 data-select mux.
- A single valid/ready input stream is steered by a 2-bit select to one of four output channels. Each output channel has its own valid/ready handshake and a one-entry holding register.
- A per-channel wrap-around transfer counter supports debug and bench checking.
- The block sits between a single producer and four independent consumers.

Parameters:
- W, 2, data width of the input and of every output channel.
- CW, 8, width of each per-channel accepted-transfer counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  the producer has a word on in_data.
- in_ready  output  1  the block accepts the input word this cycle.
- in_data  input  W  input word.
- S0  input  1  select LSB, sampled together with in_data.
- S1  input  1  select MSB. Channel index is {S1,S0}.
- D0_valid, D1_valid, D2_valid, D3_valid  output  1 each  channel n holds a valid word.
- D0_ready, D1_ready, D2_ready, D3_ready  input  1 each  consumer n accepts the word.
- D0, D1, D2, D3  output  W each  channel n data, taken directly from its holding register.
- cnt0, cnt1, cnt2, cnt3  output  CW each  number of input words accepted into channel n, modulo 2^CW.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all Dn_valid go to 0, all Dn go to 0 and all cntn go to 0.
  - in_ready is 0 during any cycle in which rst_n=0.
  - Reset mid-transfer discards held words. No output handshake completes in a reset cycle.
- Channel select: ch = {S1,S0}, meaning S1=0,S0=0 selects D0; S1=0,S0=1 selects D1; S1=1,S0=0 selects D2; S1=1,S0=1 selects D3.
- Input handshake:
  - in_ready = rst_n & (~Dch_valid | Dch_ready). It is combinational from the selected channel's state and its ready input.
  - An input transfer occurs when in_valid & in_ready.
  - in_ready may depend on S1/S0 within the same cycle. The producer must hold in_data, S0 and S1 stable while in_valid=1 and in_ready=0.
- Output handshake: an output transfer on channel n occurs when Dn_valid & Dn_ready.
- Holding-register update, per channel n, at each rising edge with rst_n=1:
  - Input transfer to n: Dn ← in_data, Dn_valid ← 1. This also covers the case where n drains in the same cycle (simultaneous drain and refill, no bubble).
  - Otherwise, output transfer on n: Dn_valid ← 0, and Dn holds its value.
  - Otherwise: hold.
- Latency: a word accepted in cycle t is presented on Dn with Dn_valid=1 in cycle t+1.
- Throughput: one word per cycle while the consumer keeps Dn_ready=1.
- Channel independence:
  - Channels not selected drain independently.
  - A stalled channel blocks only inputs that select that channel. The input stream is in order, so the producer itself stalls.
- Counters:
  - cntn increments by 1 on each input transfer to channel n.
  - It wraps from 2^CW−1 to 0 and does not increment on output transfers.
- Dn_valid, once set, stays at 1 and Dn stays stable until an output transfer on n occurs. This is the AXI-style valid rule.
- in_valid=0: no state change except output drains. in_ready is still driven, as a function of the selected channel.
- All outputs other than in_ready are registered.

Test Plan:
- Reset sequence: hold rst_n=0 for 2 cycles with in_valid=1, in_data=2'b11, S1S0=2'b10. Required: all Dn_valid=0, all Dn=0, all cntn=0, in_ready=0. Release reset with every Dn_ready=1: D2=2'b11 with D2_valid=1 one cycle later, and cnt2=1.
- Select sweep: with all Dn_ready=1, send in_data = 00, 01, 11, 11 on consecutive cycles with S1S0 = 00, 01, 10, 11. Required: D0=00, D1=01, D2=11, D3=11, each valid for exactly one cycle at t+1, and every cntn=1.
- Backpressure: hold D1_ready=0 and send two words to ch1. Required:
  - First word held on D1, valid and stable.
  - in_ready=0 for the second word, and cnt1=1.
  - Raise D1_ready: the second word appears the next cycle and cnt1=2.
- Stalled channel blocks only its own selects: D1 full with D1_ready=0, input now selects ch3. Required: in_ready=1, D3 loads, and D1 stays unchanged.
- Simultaneous drain and refill: D0 valid, D0_ready=1, new word to ch0 in the same cycle. Required: D0_valid stays 1 with no bubble and D0 updates to the new word.
- Counter wrap, using CW=2: send 5 words to ch2. Required: cnt2 follows 1, 2, 3, 0, 1. Reset asserted mid-stream clears all held words and all counters.
